// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / core reset tree.
// The master side is the sequencer; the slave side is the PLL plus reset consumers.
interface pll_reset_sequencer_if #(
    parameter int RETRY_W = 4
);
    logic               pll_locked;
    logic               pll_rst;
    logic               sys_rst;
    logic               lock_lost;
    logic               pll_fail;
    logic [RETRY_W-1:0] retries;

    modport master (
        input  pll_locked,
        output pll_rst, sys_rst, lock_lost, pll_fail, retries
    );

    modport slave (
        output pll_locked,
        input  pll_rst, sys_rst, lock_lost, pll_fail, retries
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor on refclk: pulses the PLL reset, waits for a stable lock, then
// releases the core reset. It retries on lock timeout and latches a fail flag when the retry budget is spent.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int LOCK_STABLE    = 1024,
    parameter int MAX_RETRIES    = 7,
    parameter int CNT_W          = 20,
    parameter int RETRY_W        = 4
) (
    input  logic                        refclk,
    input  logic                        rst,
    pll_reset_sequencer_if.master       bus
);
    typedef enum logic [2:0] {
        S_PLLRST, S_WAITLOCK, S_STABLE, S_RUN, S_FAIL
    } state_e;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retries_q, retries_d;
    logic [1:0]         sync_q;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_rst_q, sys_rst_d;
    logic               lock_lost_q, lock_lost_d;
    logic               pll_fail_q, pll_fail_d;
    logic               lk;

    assign lk = sync_q[1];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PLLRST;
            cnt_q       <= '0;
            retries_q   <= '0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            lock_lost_q <= 1'b0;
            pll_fail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retries_q   <= retries_d;
            sync_q      <= {sync_q[0], bus.pll_locked};
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            lock_lost_q <= lock_lost_d;
            pll_fail_q  <= pll_fail_d;
        end
    end

    // cnt only advances in the timed states and is cleared on every transition
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        unique case (state_q)
            S_PLLRST: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAITLOCK;
                    cnt_d   = '0;
                end
            end
            S_WAITLOCK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (lk) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d = '0;
                    if (retries_q == RETRY_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d   = S_PLLRST;
                        retries_d = retries_q + RETRY_W'(1);
                    end
                end
            end
            S_STABLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!lk) begin
                    state_d = S_WAITLOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    retries_d = '0;
                end
            end
            S_RUN: begin
                if (!lk) begin
                    state_d = S_PLLRST;
                    cnt_d   = '0;
                end
            end
            S_FAIL: ;
            default: begin
                state_d = S_PLLRST;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the transition edge
    always_comb begin
        pll_rst_d   = (state_d == S_PLLRST);
        sys_rst_d   = (state_d != S_RUN);
        pll_fail_d  = (state_d == S_FAIL);
        lock_lost_d = (state_q == S_RUN) && !lk;
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.pll_fail  = pll_fail_q;
    assign bus.retries   = retries_q;
endmodule
